// File: rtl/efpga_tcdm_bridge.sv
// efpga_tcdm_bridge
// Registered bridge between N eFPGA-fabric TCDM master ports and the SoC TCDM
// interconnect. Each port has a one-entry request hold register, a response
// FIFO sized to the credit limit, and a sticky spurious-response flag.
// Ports are fully independent.
//
// Optional feature macro: EFPGA_TCDM_BRIDGE_PERF_EN adds a saturating
// per-port grant counter (perf_cnt_o) with a clear input (perf_clr_i).
//
// Ports
//   CLK0, RESET            clock, synchronous active-high reset
//   fab_req_i/fab_gnt_o    fabric request handshake (per port)
//   fab_addr_i, fab_wen_i, fab_be_i, fab_wdata_i   fabric request payload
//   fab_rvalid_o/fab_rready_i, fab_rdata_o         fabric response
//   tcdm_req_o/tcdm_gnt_i  SoC request handshake
//   tcdm_addr_o, tcdm_wen_o, tcdm_be_o, tcdm_wdata_o  SoC request payload
//   tcdm_valid_i, tcdm_rdata_i                     SoC response
//   err_o, err_clr_i       sticky spurious-response flag and its clear
//   perf_cnt_o, perf_clr_i grant counters (EFPGA_TCDM_BRIDGE_PERF_EN only)
module efpga_tcdm_bridge #(
  parameter int unsigned N_PORTS   = 4,
  parameter int unsigned ADDR_W    = 20,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic                           CLK0,
  input  logic                           RESET,
  input  logic [N_PORTS-1:0]             fab_req_i,
  output logic [N_PORTS-1:0]             fab_gnt_o,
  input  logic [N_PORTS*ADDR_W-1:0]      fab_addr_i,
  input  logic [N_PORTS-1:0]             fab_wen_i,
  input  logic [N_PORTS*(DATA_W/8)-1:0]  fab_be_i,
  input  logic [N_PORTS*DATA_W-1:0]      fab_wdata_i,
  output logic [N_PORTS-1:0]             fab_rvalid_o,
  output logic [N_PORTS*DATA_W-1:0]      fab_rdata_o,
  input  logic [N_PORTS-1:0]             fab_rready_i,
  output logic [N_PORTS-1:0]             tcdm_req_o,
  output logic [N_PORTS*ADDR_W-1:0]      tcdm_addr_o,
  output logic [N_PORTS-1:0]             tcdm_wen_o,
  output logic [N_PORTS*(DATA_W/8)-1:0]  tcdm_be_o,
  output logic [N_PORTS*DATA_W-1:0]      tcdm_wdata_o,
  input  logic [N_PORTS-1:0]             tcdm_gnt_i,
  input  logic [N_PORTS-1:0]             tcdm_valid_i,
  input  logic [N_PORTS*DATA_W-1:0]      tcdm_rdata_i,
`ifdef EFPGA_TCDM_BRIDGE_PERF_EN
  output logic [N_PORTS*16-1:0]          perf_cnt_o,
  input  logic [N_PORTS-1:0]             perf_clr_i,
`endif
  output logic [N_PORTS-1:0]             err_o,
  input  logic [N_PORTS-1:0]             err_clr_i
);

  localparam int unsigned BE_W = DATA_W / 8;
  localparam int unsigned AW   = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  // One extra pointer bit distinguishes full from empty.
  localparam int unsigned PW   = AW + 1;

  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    logic              hv_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wen_q;
    logic [BE_W-1:0]   be_q;
    logic [DATA_W-1:0] wdata_q;
    logic [PW-1:0]     cnt_q;
    logic [PW-1:0]     wptr_q;
    logic [PW-1:0]     rptr_q;
    logic [DATA_W-1:0] mem_q [RSP_DEPTH];
    logic              err_q;

    logic              req_c;
    logic              issue_c;
    logic              gnt_c;
    logic              acc_c;
    logic [PW-1:0]     fill_c;
    logic [PW-1:0]     inflight_c;
    logic              empty_c;
    logic              pop_c;
    logic              spur_c;
    logic              push_c;

    // Handshake decode; tcdm_req depends only on registered state.
    always_comb begin
      req_c      = hv_q && (cnt_q < PW'(RSP_DEPTH));
      issue_c    = req_c && tcdm_gnt_i[p];
      gnt_c      = !hv_q || issue_c;
      acc_c      = fab_req_i[p] && gnt_c;
      fill_c     = wptr_q - rptr_q;
      empty_c    = (fill_c == '0);
      pop_c      = !empty_c && fab_rready_i[p];
      inflight_c = cnt_q - fill_c;
      spur_c     = tcdm_valid_i[p] && (inflight_c == '0);
      push_c     = tcdm_valid_i[p] && !spur_c;
    end

    // Request hold register; payload only changes on fabric acceptance.
    always_ff @(posedge CLK0) begin
      if (RESET) begin
        hv_q    <= 1'b0;
        addr_q  <= '0;
        wen_q   <= 1'b0;
        be_q    <= '0;
        wdata_q <= '0;
      end else if (acc_c) begin
        hv_q    <= 1'b1;
        addr_q  <= fab_addr_i[p*ADDR_W +: ADDR_W];
        wen_q   <= fab_wen_i[p];
        be_q    <= fab_be_i[p*BE_W +: BE_W];
        wdata_q <= fab_wdata_i[p*DATA_W +: DATA_W];
      end else if (issue_c) begin
        hv_q    <= 1'b0;
      end
    end

    // Credits: granted requests whose responses the fabric has not popped.
    always_ff @(posedge CLK0) begin
      if (RESET) begin
        cnt_q <= '0;
      end else if (issue_c && !pop_c) begin
        cnt_q <= cnt_q + PW'(1);
      end else if (!issue_c && pop_c) begin
        cnt_q <= cnt_q - PW'(1);
      end
    end

    // Response FIFO pointers.
    always_ff @(posedge CLK0) begin
      if (RESET) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (push_c) wptr_q <= wptr_q + PW'(1);
        if (pop_c)  rptr_q <= rptr_q + PW'(1);
      end
    end

    // FIFO storage; contents are only visible while non-empty.
    always_ff @(posedge CLK0) begin
      if (push_c) mem_q[wptr_q[AW-1:0]] <= tcdm_rdata_i[p*DATA_W +: DATA_W];
    end

    // Sticky spurious-response flag; clear wins over set.
    always_ff @(posedge CLK0) begin
      if (RESET) begin
        err_q <= 1'b0;
      end else if (err_clr_i[p]) begin
        err_q <= 1'b0;
      end else if (spur_c) begin
        err_q <= 1'b1;
      end
    end

`ifdef EFPGA_TCDM_BRIDGE_PERF_EN
    logic [15:0] perf_q;

    // Saturating TCDM grant counter; clear wins over count.
    always_ff @(posedge CLK0) begin
      if (RESET) begin
        perf_q <= '0;
      end else if (perf_clr_i[p]) begin
        perf_q <= '0;
      end else if (issue_c && (perf_q != 16'hFFFF)) begin
        perf_q <= perf_q + 16'd1;
      end
    end

    assign perf_cnt_o[p*16 +: 16] = perf_q;
`endif

    assign fab_gnt_o[p]                    = gnt_c;
    assign tcdm_req_o[p]                   = req_c;
    assign tcdm_addr_o[p*ADDR_W +: ADDR_W] = addr_q;
    assign tcdm_wen_o[p]                   = wen_q;
    assign tcdm_be_o[p*BE_W +: BE_W]       = be_q;
    assign tcdm_wdata_o[p*DATA_W +: DATA_W] = wdata_q;
    assign fab_rvalid_o[p]                 = !empty_c;
    assign fab_rdata_o[p*DATA_W +: DATA_W] = empty_c ? '0 : mem_q[rptr_q[AW-1:0]];
    assign err_o[p]                        = err_q;
  end

endmodule

// File: tb/tb_efpga_tcdm_bridge.sv
// Directed testbench for efpga_tcdm_bridge (N_PORTS=4, ADDR_W=20, DATA_W=32,
// RSP_DEPTH=4). Inputs change at posedge+1ns, outputs are sampled 1ns later.
`timescale 1ns/1ps
module tb_efpga_tcdm_bridge;
  localparam int unsigned NP = 4;
  localparam int unsigned AW = 20;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NP-1:0] fab_req, fab_gnt, fab_wen, fab_rvalid, fab_rready;
  logic [NP-1:0] tcdm_req, tcdm_wen, tcdm_gnt, tcdm_valid, err, err_clr;
  logic [NP*AW-1:0] fab_addr, tcdm_addr;
  logic [NP*BW-1:0] fab_be, tcdm_be;
  logic [NP*DW-1:0] fab_wdata, fab_rdata, tcdm_wdata, tcdm_rdata;
`ifdef EFPGA_TCDM_BRIDGE_PERF_EN
  logic [NP*16-1:0] perf_cnt;
  logic [NP-1:0]    perf_clr;
`endif

  int checks = 0;
  int failures = 0;

  // Credit-test scratch state
  int          cr_issued, cr_grants;
  logic        cr_pend;
  logic [31:0] cr_pdata;
  logic [31:0] cr_got[$];

  // Concurrent-test scratch state
  int n_acc[NP], n_gnt[NP], n_rsp[NP], n_pop[NP];
  int rdy_t[NP][16];

  always #5 clk = ~clk;

  efpga_tcdm_bridge #(.N_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RSP_DEPTH(4)) dut (
    .CLK0(clk), .RESET(rst),
    .fab_req_i(fab_req), .fab_gnt_o(fab_gnt), .fab_addr_i(fab_addr),
    .fab_wen_i(fab_wen), .fab_be_i(fab_be), .fab_wdata_i(fab_wdata),
    .fab_rvalid_o(fab_rvalid), .fab_rdata_o(fab_rdata), .fab_rready_i(fab_rready),
    .tcdm_req_o(tcdm_req), .tcdm_addr_o(tcdm_addr), .tcdm_wen_o(tcdm_wen),
    .tcdm_be_o(tcdm_be), .tcdm_wdata_o(tcdm_wdata), .tcdm_gnt_i(tcdm_gnt),
    .tcdm_valid_i(tcdm_valid), .tcdm_rdata_i(tcdm_rdata),
`ifdef EFPGA_TCDM_BRIDGE_PERF_EN
    .perf_cnt_o(perf_cnt), .perf_clr_i(perf_clr),
`endif
    .err_o(err), .err_clr_i(err_clr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fab_req = '0; fab_addr = '0; fab_wen = '0; fab_be = '0; fab_wdata = '0;
    fab_rready = '1; tcdm_gnt = '0; tcdm_valid = '0; tcdm_rdata = '0;
    err_clr = '0;
`ifdef EFPGA_TCDM_BRIDGE_PERF_EN
    perf_clr = '0;
`endif
  endtask

  function automatic logic [AW-1:0] taddr(int p);
    return tcdm_addr[p*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] frdata(int p);
    return fab_rdata[p*DW +: DW];
  endfunction

  function automatic logic [AW-1:0] cc_addr(int p, int k);
    return AW'(p * 4096 + 768 + k);
  endfunction

  function automatic logic [DW-1:0] cc_data(int p, int k);
    return 32'hD000_0000 | DW'(p * 256 + k);
  endfunction

  function automatic logic [DW-1:0] cc_wdata(int p, int k);
    return 32'h5000_0000 | DW'(p * 65536 + k);
  endfunction

  task automatic test_reset();
    idle();
    rst = 1'b1;
    step(); step();
    checks++; if (fab_gnt !== 4'hF) begin failures++; $display("FAIL reset_fab_gnt got=%h exp=f", fab_gnt); end
    checks++; if (fab_rvalid !== 4'h0) begin failures++; $display("FAIL reset_fab_rvalid got=%h exp=0", fab_rvalid); end
    checks++; if (tcdm_req !== 4'h0) begin failures++; $display("FAIL reset_tcdm_req got=%h exp=0", tcdm_req); end
    checks++; if (tcdm_addr !== '0 || tcdm_wen !== '0 || tcdm_be !== '0 || tcdm_wdata !== '0) begin
      failures++; $display("FAIL reset_payload addr=%h wen=%h be=%h wdata=%h exp=0", tcdm_addr, tcdm_wen, tcdm_be, tcdm_wdata); end
    checks++; if (fab_rdata !== '0) begin failures++; $display("FAIL reset_fab_rdata got=%h exp=0", fab_rdata); end
    checks++; if (err !== 4'h0) begin failures++; $display("FAIL reset_err got=%h exp=0", err); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_read();
    idle();
    fab_req[0] = 1'b1; fab_addr[0 +: AW] = 20'h00040; fab_wen[0] = 1'b1;
    fab_be[0 +: BW] = 4'hF; tcdm_gnt[0] = 1'b1;
    #1;
    checks++; if (fab_gnt[0] !== 1'b1) begin failures++; $display("FAIL single_accept got=%b exp=1", fab_gnt[0]); end
    step();
    fab_req[0] = 1'b0;
    #1;
    checks++; if (tcdm_req[0] !== 1'b1 || taddr(0) !== 20'h00040 || tcdm_wen[0] !== 1'b1) begin
      failures++; $display("FAIL single_tcdm_req req=%b addr=%h wen=%b exp=1/00040/1", tcdm_req[0], taddr(0), tcdm_wen[0]); end
    step();
    tcdm_valid[0] = 1'b1; tcdm_rdata[0 +: DW] = 32'hDEADBEEF;
    #1;
    checks++; if (tcdm_req[0] !== 1'b0 || fab_rvalid[0] !== 1'b0) begin
      failures++; $display("FAIL single_after_grant req=%b rvalid=%b exp=0/0", tcdm_req[0], fab_rvalid[0]); end
    step();
    tcdm_valid[0] = 1'b0;
    #1;
    checks++; if (fab_rvalid[0] !== 1'b1 || frdata(0) !== 32'hDEADBEEF) begin
      failures++; $display("FAIL single_rsp rvalid=%b rdata=%h exp=1/deadbeef", fab_rvalid[0], frdata(0)); end
    step();
    checks++; if (fab_rvalid[0] !== 1'b0) begin failures++; $display("FAIL single_popped rvalid=%b exp=0", fab_rvalid[0]); end
    // Credits back to zero: another response must now be flagged spurious.
    tcdm_valid[0] = 1'b1;
    step();
    tcdm_valid[0] = 1'b0;
    checks++; if (err[0] !== 1'b1 || fab_rvalid[0] !== 1'b0) begin
      failures++; $display("FAIL single_cnt_zero err=%b rvalid=%b exp=1/0", err[0], fab_rvalid[0]); end
    err_clr[0] = 1'b1;
    step();
    err_clr[0] = 1'b0;
  endtask

  task automatic test_grant_stall();
    int grants;
    idle();
    grants = 0;
    fab_req[1] = 1'b1; fab_addr[AW +: AW] = 20'h12345; fab_wen[1] = 1'b0;
    fab_be[BW +: BW] = 4'hA; fab_wdata[DW +: DW] = 32'hCAFEF00D;
    #1;
    checks++; if (fab_gnt[1] !== 1'b1) begin failures++; $display("FAIL stall_accept got=%b exp=1", fab_gnt[1]); end
    step();
    fab_addr[AW +: AW] = 20'h0ABCD; fab_be[BW +: BW] = 4'h5; fab_wdata[DW +: DW] = 32'h55555555;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (tcdm_req[1] !== 1'b1 || taddr(1) !== 20'h12345 || tcdm_be[BW +: BW] !== 4'hA ||
                    tcdm_wdata[DW +: DW] !== 32'hCAFEF00D || tcdm_wen[1] !== 1'b0) begin
        failures++; $display("FAIL stall_hold cyc=%0d req=%b addr=%h be=%h wdata=%h exp=1/12345/a/cafef00d",
                             i, tcdm_req[1], taddr(1), tcdm_be[BW +: BW], tcdm_wdata[DW +: DW]); end
      checks++; if (fab_gnt[1] !== 1'b0) begin failures++; $display("FAIL stall_fab_gnt cyc=%0d got=%b exp=0", i, fab_gnt[1]); end
      if (tcdm_req[1] && tcdm_gnt[1]) grants++;
      step();
    end
    fab_req[1] = 1'b0; tcdm_gnt[1] = 1'b1;
    #1;
    if (tcdm_req[1] && tcdm_gnt[1]) grants++;
    step();
    #1;
    if (tcdm_req[1] && tcdm_gnt[1]) grants++;
    checks++; if (grants !== 1) begin failures++; $display("FAIL stall_grants got=%0d exp=1", grants); end
    tcdm_gnt[1] = 1'b0; tcdm_valid[1] = 1'b1; tcdm_rdata[DW +: DW] = 32'h0;
    step();
    tcdm_valid[1] = 1'b0;
    #1;
    checks++; if (fab_rvalid[1] !== 1'b1) begin failures++; $display("FAIL stall_write_rsp got=%b exp=1", fab_rvalid[1]); end
    step();
    checks++; if (fab_rvalid[1] !== 1'b0 || err[1] !== 1'b0) begin
      failures++; $display("FAIL stall_drain rvalid=%b err=%b exp=0/0", fab_rvalid[1], err[1]); end
  endtask

  task automatic test_back_to_back();
    idle();
    tcdm_gnt[1] = 1'b1; fab_wen[1] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      fab_req[1] = (i < 4);
      fab_addr[AW +: AW] = 20'h00200 + AW'(i);
      tcdm_valid[1] = (i >= 2 && i < 6);
      tcdm_rdata[DW +: DW] = 32'hB000_0000 + DW'(i - 2);
      #1;
      if (i < 4) begin
        checks++; if (fab_gnt[1] !== 1'b1) begin failures++; $display("FAIL b2b_fab_gnt cyc=%0d got=%b exp=1", i, fab_gnt[1]); end
      end
      if (i >= 1 && i <= 4) begin
        checks++; if (tcdm_req[1] !== 1'b1 || taddr(1) !== 20'h00200 + AW'(i - 1)) begin
          failures++; $display("FAIL b2b_issue cyc=%0d req=%b addr=%h exp=1/%h", i, tcdm_req[1], taddr(1), 20'h00200 + AW'(i - 1)); end
      end
      if (i >= 3 && i <= 6) begin
        checks++; if (fab_rvalid[1] !== 1'b1 || frdata(1) !== 32'hB000_0000 + DW'(i - 3)) begin
          failures++; $display("FAIL b2b_rsp cyc=%0d rvalid=%b rdata=%h exp=1/%h", i, fab_rvalid[1], frdata(1), 32'hB000_0000 + DW'(i - 3)); end
      end
      step();
    end
    checks++; if (fab_rvalid[1] !== 1'b0 || tcdm_req[1] !== 1'b0 || err[1] !== 1'b0) begin
      failures++; $display("FAIL b2b_idle rvalid=%b req=%b err=%b exp=0/0/0", fab_rvalid[1], tcdm_req[1], err[1]); end
  endtask

  // One cycle of port 3 with a one-cycle-latency TCDM responder.
  task automatic cr_cycle();
    logic          acc, gr;
    logic [AW-1:0] ga;
    fab_req[3] = (cr_issued < 6);
    fab_addr[3*AW +: AW] = 20'h00100 + AW'(cr_issued);
    tcdm_valid[3] = cr_pend;
    tcdm_rdata[3*DW +: DW] = cr_pdata;
    #1;
    acc = fab_req[3] && fab_gnt[3];
    gr  = tcdm_req[3] && tcdm_gnt[3];
    ga  = taddr(3);
    if (fab_rvalid[3] && fab_rready[3]) cr_got.push_back(frdata(3));
    step();
    if (acc) cr_issued++;
    if (gr) cr_grants++;
    cr_pend  = gr;
    cr_pdata = 32'hA000_0000 | DW'(ga);
  endtask

  task automatic test_credit_limit();
    idle();
    cr_issued = 0; cr_grants = 0; cr_pend = 1'b0; cr_pdata = '0; cr_got.delete();
    fab_wen[3] = 1'b1; fab_be[3*BW +: BW] = 4'hF; tcdm_gnt[3] = 1'b1; fab_rready[3] = 1'b0;
    for (int i = 0; i < 12; i++) cr_cycle();
    checks++; if (cr_grants !== 4 || cr_issued !== 5) begin
      failures++; $display("FAIL credit_grants grants=%0d accepted=%0d exp=4/5", cr_grants, cr_issued); end
    checks++; if (tcdm_req[3] !== 1'b0 || fab_gnt[3] !== 1'b0) begin
      failures++; $display("FAIL credit_block req=%b fab_gnt=%b exp=0/0", tcdm_req[3], fab_gnt[3]); end
    checks++; if (fab_rvalid[3] !== 1'b1 || frdata(3) !== 32'hA000_0100) begin
      failures++; $display("FAIL credit_head rvalid=%b rdata=%h exp=1/a0000100", fab_rvalid[3], frdata(3)); end
    fab_rready[3] = 1'b1;
    cr_cycle();
    fab_rready[3] = 1'b0;
    checks++; if (tcdm_req[3] !== 1'b1 || taddr(3) !== 20'h00104) begin
      failures++; $display("FAIL credit_resume req=%b addr=%h exp=1/00104", tcdm_req[3], taddr(3)); end
    fab_rready[3] = 1'b1;
    for (int i = 0; i < 15; i++) cr_cycle();
    checks++; if (cr_grants !== 6 || cr_got.size() !== 6) begin
      failures++; $display("FAIL credit_total grants=%0d pops=%0d exp=6/6", cr_grants, cr_got.size()); end
    for (int k = 0; k < 6; k++) begin
      if (k < cr_got.size()) begin
        checks++; if (cr_got[k] !== 32'hA000_0100 + DW'(k)) begin
          failures++; $display("FAIL credit_order idx=%0d got=%h exp=%h", k, cr_got[k], 32'hA000_0100 + DW'(k)); end
      end
    end
    idle();
    step();
  endtask

  task automatic test_concurrent();
    logic [NP-1:0] acc, gr, pop, vld;
    logic          exp_wen;
    int            k, kr;
    bit            done;
    idle();
    for (int p = 0; p < NP; p++) begin
      n_acc[p] = 0; n_gnt[p] = 0; n_rsp[p] = 0; n_pop[p] = 0;
    end
    done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      for (int p = 0; p < NP; p++) begin
        k  = (n_acc[p] < 16) ? n_acc[p] : 15;
        kr = (n_rsp[p] < 16) ? n_rsp[p] : 15;
        fab_req[p] = (n_acc[p] < 16);
        fab_addr[p*AW +: AW] = cc_addr(p, k);
        fab_wen[p] = (k >= 8);
        fab_be[p*BW +: BW] = BW'(k + 1);
        fab_wdata[p*DW +: DW] = cc_wdata(p, k);
        vld[p] = (n_rsp[p] < n_gnt[p]) && (rdy_t[p][kr] <= c);
        tcdm_valid[p] = vld[p];
        tcdm_rdata[p*DW +: DW] = cc_data(p, kr);
        tcdm_gnt[p] = 1'($urandom_range(0, 1));
        fab_rready[p] = ($urandom_range(0, 3) != 0);
      end
      #1;
      for (int p = 0; p < NP; p++) begin
        acc[p] = fab_req[p] && fab_gnt[p];
        gr[p]  = tcdm_req[p] && tcdm_gnt[p];
        pop[p] = fab_rvalid[p] && fab_rready[p];
        if (gr[p]) begin
          k = (n_gnt[p] < 16) ? n_gnt[p] : 15;
          exp_wen = (k >= 8);
          checks++; if (taddr(p) !== cc_addr(p, k) || tcdm_wen[p] !== exp_wen ||
                        (!exp_wen && tcdm_wdata[p*DW +: DW] !== cc_wdata(p, k))) begin
            failures++; $display("FAIL conc_issue port=%0d idx=%0d addr=%h wen=%b wdata=%h exp=%h/%b/%h",
                                 p, k, taddr(p), tcdm_wen[p], tcdm_wdata[p*DW +: DW], cc_addr(p, k), exp_wen, cc_wdata(p, k)); end
          rdy_t[p][k] = c + 1 + int'($urandom_range(0, 3));
        end
        if (pop[p]) begin
          k = n_pop[p];
          checks++; if (frdata(p) !== cc_data(p, k)) begin
            failures++; $display("FAIL conc_rsp port=%0d idx=%0d got=%h exp=%h", p, k, frdata(p), cc_data(p, k)); end
        end
      end
      step();
      done = 1'b1;
      for (int p = 0; p < NP; p++) begin
        if (acc[p]) n_acc[p]++;
        if (gr[p])  n_gnt[p]++;
        if (vld[p]) n_rsp[p]++;
        if (pop[p]) n_pop[p]++;
        if (n_pop[p] < 16) done = 1'b0;
      end
    end
    for (int p = 0; p < NP; p++) begin
      checks++; if (n_pop[p] !== 16 || n_gnt[p] !== 16) begin
        failures++; $display("FAIL conc_complete port=%0d pops=%0d grants=%0d exp=16/16", p, n_pop[p], n_gnt[p]); end
    end
    checks++; if (err !== 4'h0) begin failures++; $display("FAIL conc_err got=%h exp=0", err); end
    idle();
    step();
  endtask

  task automatic test_spurious();
    idle();
    tcdm_valid[2] = 1'b1; tcdm_rdata[2*DW +: DW] = 32'h11111111;
    step();
    tcdm_valid[2] = 1'b0;
    checks++; if (err !== 4'b0100) begin failures++; $display("FAIL spur_set got=%b exp=0100", err); end
    checks++; if (fab_rvalid[2] !== 1'b0) begin failures++; $display("FAIL spur_no_push got=%b exp=0", fab_rvalid[2]); end
    err_clr[2] = 1'b1;
    step();
    err_clr[2] = 1'b0;
    checks++; if (err[2] !== 1'b0) begin failures++; $display("FAIL spur_clear got=%b exp=0", err[2]); end
    tcdm_valid[2] = 1'b1; err_clr[2] = 1'b1;
    step();
    tcdm_valid[2] = 1'b0; err_clr[2] = 1'b0;
    checks++; if (err[2] !== 1'b0 || fab_rvalid[2] !== 1'b0) begin
      failures++; $display("FAIL spur_clr_priority err=%b rvalid=%b exp=0/0", err[2], fab_rvalid[2]); end
  endtask

  task automatic test_reset_mid_burst();
    idle();
    fab_rready[0] = 1'b0; tcdm_gnt[0] = 1'b1; fab_wen[0] = 1'b1; fab_be[0 +: BW] = 4'h3;
    for (int i = 0; i < 3; i++) begin
      fab_req[0] = 1'b1; fab_addr[0 +: AW] = 20'h00700 + AW'(i);
      step();
    end
    fab_req[0] = 1'b1; fab_addr[0 +: AW] = 20'h00703;
    checks++; if (tcdm_req[0] !== 1'b1 || taddr(0) !== 20'h00702) begin
      failures++; $display("FAIL rst_burst_pre req=%b addr=%h exp=1/00702", tcdm_req[0], taddr(0)); end
    rst = 1'b1;
    step();
    checks++; if (fab_gnt !== 4'hF || tcdm_req !== 4'h0 || fab_rvalid !== 4'h0 || err !== 4'h0) begin
      failures++; $display("FAIL rst_burst_ctrl gnt=%h req=%h rvalid=%h err=%h exp=f/0/0/0", fab_gnt, tcdm_req, fab_rvalid, err); end
    checks++; if (tcdm_addr !== '0 || tcdm_be !== '0 || tcdm_wen !== '0 || fab_rdata !== '0) begin
      failures++; $display("FAIL rst_burst_data addr=%h be=%h wen=%h rdata=%h exp=0", tcdm_addr, tcdm_be, tcdm_wen, fab_rdata); end
    rst = 1'b0;
    idle();
    tcdm_valid[0] = 1'b1; tcdm_rdata[0 +: DW] = 32'h77777777;
    step();
    tcdm_valid[0] = 1'b0;
    checks++; if (err[0] !== 1'b1 || fab_rvalid[0] !== 1'b0) begin
      failures++; $display("FAIL rst_late_valid err=%b rvalid=%b exp=1/0", err[0], fab_rvalid[0]); end
    err_clr[0] = 1'b1;
    step();
    err_clr[0] = 1'b0;
  endtask

`ifdef EFPGA_TCDM_BRIDGE_PERF_EN
  task automatic test_perf();
    idle();
    perf_clr = '1;
    step();
    perf_clr = '0;
    checks++; if (perf_cnt !== '0) begin failures++; $display("FAIL perf_clear got=%h exp=0", perf_cnt); end
    fab_req[0] = 1'b1; fab_wen[0] = 1'b1; tcdm_gnt[0] = 1'b1;
    for (int c = 0; c < 70010; c++) begin
      tcdm_valid[0] = (c >= 2);
      step();
    end
    fab_req[0] = 1'b0;
    step(); step();
    tcdm_valid[0] = 1'b0;
    step();
    checks++; if (perf_cnt[0 +: 16] !== 16'hFFFF || perf_cnt[16 +: 16] !== 16'h0) begin
      failures++; $display("FAIL perf_saturate p0=%h p1=%h exp=ffff/0000", perf_cnt[0 +: 16], perf_cnt[16 +: 16]); end
    checks++; if (err[0] !== 1'b0 || fab_rvalid[0] !== 1'b0) begin
      failures++; $display("FAIL perf_drain err=%b rvalid=%b exp=0/0", err[0], fab_rvalid[0]); end
    perf_clr[0] = 1'b1;
    step();
    perf_clr[0] = 1'b0;
    checks++; if (perf_cnt[0 +: 16] !== 16'h0) begin failures++; $display("FAIL perf_clr got=%h exp=0", perf_cnt[0 +: 16]); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_single_read();
    test_grant_stall();
    test_back_to_back();
    test_credit_limit();
    test_concurrent();
    test_spurious();
    test_reset_mid_burst();
`ifdef EFPGA_TCDM_BRIDGE_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/efpga_tcdm_bridge.md
# efpga_tcdm_bridge

Parametrised, registered bridge between N eFPGA-fabric TCDM master ports and the SoC TCDM interconnect; successor to the fixed four-port, purely wired TCDM mapping in the eFPGA wrapper. Each port holds a one-entry request register and a response FIFO, and applies credit-based flow control so no response is ever dropped. Each port also flags spurious responses. It sits inside the eFPGA wrapper between the fabric pad bus and the `tcdm_*` ports.

## Interface
- `N_PORTS`, 4: number of independent TCDM channels (1–8).
- `ADDR_W`, 20: word-address width.
- `DATA_W`, 32: data width, multiple of 8; `BE_W = DATA_W/8`.
- `RSP_DEPTH`, 4: response FIFO depth and max outstanding per port, power of 2, ≥2.
- `CLK0  in  1`: sole clock, rising edge.
- `RESET  in  1`: synchronous, active-high reset.
- `fab_req_i  in  N_PORTS`: fabric request per port.
- `fab_gnt_o  out  N_PORTS`: request accepted this cycle.
- `fab_addr_i  in  N_PORTS*ADDR_W`, `fab_wen_i  in  N_PORTS` (1=read), `fab_be_i  in  N_PORTS*BE_W`, `fab_wdata_i  in  N_PORTS*DATA_W`: request payload; port p at slice p.
- `fab_rvalid_o  out  N_PORTS`, `fab_rdata_o  out  N_PORTS*DATA_W`, `fab_rready_i  in  N_PORTS`: response handshake to fabric.
- `tcdm_req_o  out  N_PORTS`, `tcdm_addr_o`, `tcdm_wen_o`, `tcdm_be_o`, `tcdm_wdata_o`  out: SoC-side request, same widths as the fabric side.
- `tcdm_gnt_i  in  N_PORTS`, `tcdm_valid_i  in  N_PORTS`, `tcdm_rdata_i  in  N_PORTS*DATA_W`: SoC-side grant and response.
- `err_o  out  N_PORTS`: sticky spurious-response flag.
- `err_clr_i  in  N_PORTS`: clears `err_o[p]`.

## Operation
- Ports are fully independent; all following rules apply per port p.
- Hold register `hv` plus payload:
  - `fab_gnt_o = !hv || (tcdm_req_o && tcdm_gnt_i)`.
  - On `fab_req_i && fab_gnt_o`, payload is captured and `hv` is set.
  - `hv` clears on a TCDM grant with no new fabric acceptance in the same cycle.
- Credit counter `cnt` (0..RSP_DEPTH) counts requests granted by TCDM whose responses have not yet been popped by the fabric.
  - `tcdm_req_o = hv && (cnt < RSP_DEPTH)`.
  - `cnt` increments on TCDM grant and decrements on pop (`fab_rvalid_o && fab_rready_i`); both in one cycle leaves it unchanged.
- `tcdm_*` payload outputs are driven directly from the hold register. They stay stable while `tcdm_req_o && !tcdm_gnt_i`.
- Every granted transaction, read or write, returns exactly one `tcdm_valid_i`. `tcdm_rdata_i` is pushed to the FIFO; write data is don't-care.
- FIFO:
  - `fab_rvalid_o = !empty`; `fab_rdata_o` = head entry, registered.
  - Pointers are `log2(RSP_DEPTH)+1` bits and wrap naturally.
  - Push and pop in one cycle are both honoured, including when the FIFO is full.
  - Overflow cannot occur, because credits bound it.
- Spurious response: `tcdm_valid_i` while in-flight (`cnt - fifo_count`) is 0.
  - The response is not pushed and `err_o[p]` is set.
  - `err_clr_i` has priority over a simultaneous set.
- Reset clears `hv`, `cnt`, FIFO pointers and `err_o`. Responses arriving after reset for requests granted before it are reported as spurious; software quiesces the TCDM before asserting `RESET`.

## Timing
- Reset values: `fab_gnt_o` = all 1, `fab_rvalid_o` = 0, `tcdm_req_o` = 0, payload outputs = 0, `fab_rdata_o` = 0, `err_o` = 0.
- Request path:
  - A request accepted in cycle N drives `tcdm_req_o` in cycle N+1.
  - Back-to-back throughput is 1 per cycle while `tcdm_gnt_i` = 1 and credits remain.
- Response path: `tcdm_valid_i` in cycle M drives `fab_rvalid_o` in cycle M+1.
- With `fab_rready_i` held at 1, round trip is request-accept → data = 2 + TCDM latency.
- No combinational path from any `tcdm_*` input to any `tcdm_*` output.

## Configuration
- `EFPGA_TCDM_BRIDGE_PERF_EN` defined:
  - Adds `perf_cnt_o  out  N_PORTS*16` and `perf_clr_i  in  N_PORTS`.
  - The counter counts TCDM grants and saturates at 16'hFFFF.
  - `perf_clr_i` zeroes it and takes priority over a simultaneous count.
  - Reset value is 0.
- Not defined: these ports and the counters do not exist; all other behaviour is identical.

## Test plan
- Single read, port 0: addr 20'h00040, `tcdm_gnt_i` immediate, `tcdm_valid_i` one cycle later with 32'hDEADBEEF → `tcdm_req_o[0]` high 1 cycle after accept; `fab_rvalid_o[0]` with DEADBEEF 1 cycle after valid; `cnt` returns to 0.
- Grant stall: `tcdm_gnt_i` low 5 cycles → `tcdm_addr_o`/`wdata`/`be` unchanged for all 5 cycles; `fab_gnt_o` low; exactly one transaction granted.
- Credit limit, `RSP_DEPTH`=4: `fab_rready_i`=0, 6 reads → exactly 4 grants, then `tcdm_req_o` low. Pop one → fifth is issued the next cycle. Data is returned in order.
- Concurrent ports: ports 0–3 each issue 8 writes plus 8 reads with randomized gnt/valid delays → per-port in-order data, no cross-port corruption.
- Spurious valid on port 2 with `cnt`=0 → `err_o[2]`=1 the next cycle, FIFO unchanged. `err_clr_i[2]` → 0. Set and clear in the same cycle → 0.
- Reset mid-burst with 3 outstanding → all outputs at reset values the cycle after. A late `tcdm_valid_i` sets `err_o`. With PERF_EN: after 70000 grants, `perf_cnt_o` = 16'hFFFF.
